// File: rtl/pim_bank_gather_if.sv
`default_nettype none
// ============================================================================
//  Module   : pim_bank_gather_if
//  Purpose  : Four-bank valid/ready gather bus plus the single registered
//             output stream toward the bus-side read path.
//  Revision : 1.0  initial release
// ============================================================================
interface pim_bank_gather_if #(
   parameter int WIDTH = 256
);
   logic             i_ordered;
   logic             i_valid0;
   logic             i_valid1;
   logic             i_valid2;
   logic             i_valid3;
   logic [WIDTH-1:0] i_data0;
   logic [WIDTH-1:0] i_data1;
   logic [WIDTH-1:0] i_data2;
   logic [WIDTH-1:0] i_data3;
   logic             o_ready0;
   logic             o_ready1;
   logic             o_ready2;
   logic             o_ready3;
   logic             o_valid;
   logic [WIDTH-1:0] o_data;
   logic [1:0]       o_src;
   logic             o_last;
   logic             i_ready;
   logic             o_busy;

   // Gather block side
   modport slave (
      input  i_ordered,
      input  i_valid0, i_valid1, i_valid2, i_valid3,
      input  i_data0, i_data1, i_data2, i_data3,
      input  i_ready,
      output o_ready0, o_ready1, o_ready2, o_ready3,
      output o_valid, o_data, o_src, o_last, o_busy
   );

   // Bank sources and downstream consumer side
   modport master (
      output i_ordered,
      output i_valid0, i_valid1, i_valid2, i_valid3,
      output i_data0, i_data1, i_data2, i_data3,
      output i_ready,
      input  o_ready0, o_ready1, o_ready2, o_ready3,
      input  o_valid, o_data, o_src, o_last, o_busy
   );
endinterface
`default_nettype wire

// File: rtl/pim_bank_gather.sv
`default_nettype none
// ============================================================================
//  Module   : pim_bank_gather
//  Purpose  : Gathers result words from four PIM banks into one registered
//             output stream. Round-robin arbitration, or strict bank order
//             0,1,2,3 when a full row is being reassembled.
//  Revision : 1.0  initial release
// ============================================================================
module pim_bank_gather #(
   parameter int WIDTH = 256   // must match the WIDTH of the connected interface
) (
   input  logic              i_clk,
   input  logic              i_rst,
   pim_bank_gather_if.slave  bus
);

   logic [3:0]       w_valid;
   logic             w_load_ok;
   logic             w_gnt_any;
   logic [1:0]       w_gnt;
   logic [1:0]       w_cand;
   logic             w_xfer;
   logic [WIDTH-1:0] w_data_sel;

   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic [1:0]       r_src;
   logic             r_last;
   logic [1:0]       r_ptr;   // round-robin: bank with highest priority
   logic [1:0]       r_idx;   // ordered mode: next bank expected in the row

   assign w_valid   = {bus.i_valid3, bus.i_valid2, bus.i_valid1, bus.i_valid0};

   // The output register can take a new word when empty or draining this cycle
   assign w_load_ok = !r_valid | bus.i_ready;

   // Select the granted bank; the scan runs from the farthest offset down so
   // the closest valid bank to the pointer is the one left standing.
   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt     = 2'd0;
      w_cand    = r_ptr;
      if (bus.i_ordered) begin
         w_gnt     = r_idx;
         w_gnt_any = w_valid[r_idx];
      end else begin
         for (int k = 3; k >= 0; k--) begin
            w_cand = r_ptr + 2'(k);
            if (w_valid[w_cand]) begin
               w_gnt     = w_cand;
               w_gnt_any = 1'b1;
            end
         end
      end
   end

   // Reset gating keeps every bank ready low while the block is held in reset
   assign w_xfer = w_load_ok & w_gnt_any & !i_rst;

   assign bus.o_ready0 = w_xfer & (w_gnt == 2'd0);
   assign bus.o_ready1 = w_xfer & (w_gnt == 2'd1);
   assign bus.o_ready2 = w_xfer & (w_gnt == 2'd2);
   assign bus.o_ready3 = w_xfer & (w_gnt == 2'd3);

   // Route the granted bank's word toward the output register
   always_comb begin
      w_data_sel = bus.i_data0;
      case (w_gnt)
         2'd0:    w_data_sel = bus.i_data0;
         2'd1:    w_data_sel = bus.i_data1;
         2'd2:    w_data_sel = bus.i_data2;
         default: w_data_sel = bus.i_data3;
      endcase
   end

   // Output register: load on transfer, empty when drained with nothing to load,
   // hold everything while stalled
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_src   <= 2'd0;
         r_last  <= 1'b0;
      end else if (w_load_ok) begin
         if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_data_sel;
            r_src   <= w_gnt;
            r_last  <= bus.i_ordered & (w_gnt == 2'd3);
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

   // Arbitration state: the pointer only moves in round-robin mode, the row
   // index only advances in ordered mode and is parked at 0 otherwise
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ptr <= 2'd0;
         r_idx <= 2'd0;
      end else begin
         if (!bus.i_ordered) begin
            r_idx <= 2'd0;
            if (w_xfer) begin
               r_ptr <= w_gnt + 2'd1;
            end
         end else if (w_xfer) begin
            r_idx <= w_gnt + 2'd1;
         end
      end
   end

   assign bus.o_valid = r_valid;
   assign bus.o_data  = r_data;
   assign bus.o_src   = r_src;
   assign bus.o_last  = r_last;
   assign bus.o_busy  = r_valid | (r_idx != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_pim_bank_gather.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pim_bank_gather
//  Purpose  : Self-checking bench for pim_bank_gather: bank sources driven
//             from per-bank queues, a transaction-level model of the
//             arbitration rules, and a per-bank delivery scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pim_bank_gather;
   localparam int WIDTH = 256;
   typedef logic [WIDTH-1:0] word_t;

   logic clk;
   logic rst;

   pim_bank_gather_if #(.WIDTH(WIDTH)) bus ();

   pim_bank_gather #(.WIDTH(WIDTH)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int         total = 0;
   int         bad   = 0;
   word_t      src_q [4][$];   // words each bank source still has to offer
   word_t      exp_q [4][$];   // words each bank must still deliver, in order
   logic [3:0] en  = 4'b0000;  // bank source enables
   logic [3:0] acc = 4'b0000;  // banks whose word was taken at the coming edge
   int         out_src [$];
   logic       out_last[$];
   word_t      out_data[$];
   int         exp_src [$];

   // model state: output register contents, rr pointer, ordered row position
   logic  m_valid, n_valid;
   word_t m_data,  n_data;
   int    m_src,   n_src;
   logic  m_last,  n_last;
   int    m_ptr,   n_ptr;
   int    m_idx,   n_idx;

   task automatic chk(input string name, input word_t act, input word_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] rdy_vec();
      return {bus.o_ready3, bus.o_ready2, bus.o_ready1, bus.o_ready0};
   endfunction

   function automatic logic [3:0] val_vec();
      return {bus.i_valid3, bus.i_valid2, bus.i_valid1, bus.i_valid0};
   endfunction

   // Which bank the rules say wins this cycle (-1: none)
   function automatic int exp_grant();
      logic [3:0] v;
      v = val_vec();
      if (m_valid && !bus.i_ready) return -1;
      if (bus.i_ordered) return v[m_idx] ? m_idx : -1;
      for (int k = 0; k < 4; k++) begin
         if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
      end
      return -1;
   endfunction

   // Compare process: check DUT against model, scoreboard deliveries,
   // and work out the model state after the coming edge
   always @(negedge clk) begin
      int         g;
      int         b;
      logic [3:0] rdy;
      logic [3:0] er;
      rdy = rdy_vec();
      if (rst) begin
         chk("ready_in_reset", WIDTH'(rdy), '0);
         chk("valid_in_reset", WIDTH'(bus.o_valid), '0);
         acc     = 4'b0000;
         n_valid = 1'b0; n_data = '0; n_src = 0; n_last = 1'b0; n_ptr = 0; n_idx = 0;
      end else begin
         g  = exp_grant();
         er = (g >= 0) ? (4'b0001 << g) : 4'b0000;
         chk("ready", WIDTH'(rdy), WIDTH'(er));
         chk("o_valid", WIDTH'(bus.o_valid), WIDTH'(m_valid));
         chk("o_busy", WIDTH'(bus.o_busy), WIDTH'(m_valid || (m_idx != 0)));
         if (m_valid) begin
            chk("o_data", bus.o_data, m_data);
            chk("o_src", WIDTH'(bus.o_src), WIDTH'(m_src));
            chk("o_last", WIDTH'(bus.o_last), WIDTH'(m_last));
         end
         acc = rdy;
         if (bus.o_valid && bus.i_ready) begin
            b = int'(bus.o_src);
            if (exp_q[b].size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_unexpected: got word from bank %0d, expected none", b);
            end else begin
               chk("sb_order", bus.o_data, exp_q[b][0]);
               void'(exp_q[b].pop_front());
            end
            out_src.push_back(b);
            out_last.push_back(bus.o_last);
            out_data.push_back(bus.o_data);
         end
         n_valid = m_valid; n_data = m_data; n_src = m_src; n_last = m_last;
         n_ptr   = m_ptr;   n_idx  = m_idx;
         if (!m_valid || bus.i_ready) begin
            if (g >= 0) begin
               n_valid = 1'b1;
               n_data  = src_q[g][0];
               n_src   = g;
               n_last  = bus.i_ordered && (g == 3);
               if (!bus.i_ordered) n_ptr = (g + 1) % 4;
            end else begin
               n_valid = 1'b0;
            end
         end
         if (!bus.i_ordered) n_idx = 0;
         else if (g >= 0)    n_idx = (g + 1) % 4;
      end
   end

   // Model commit, reset the same way the block does
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0; m_data <= '0; m_src <= 0; m_last <= 1'b0; m_ptr <= 0; m_idx <= 0;
      end else begin
         m_valid <= n_valid; m_data <= n_data; m_src <= n_src; m_last <= n_last;
         m_ptr   <= n_ptr;   m_idx  <= n_idx;
      end
   end

   function automatic word_t head(input int b);
      return (src_q[b].size() != 0) ? src_q[b][0] : '0;
   endfunction

   function automatic logic has(input int b);
      return en[b] && (src_q[b].size() != 0);
   endfunction

   task automatic drive();
      bus.i_valid0 = has(0); bus.i_data0 = head(0);
      bus.i_valid1 = has(1); bus.i_data1 = head(1);
      bus.i_valid2 = has(2); bus.i_data2 = head(2);
      bus.i_valid3 = has(3); bus.i_data3 = head(3);
   endtask

   task automatic push(input int b, input word_t w);
      src_q[b].push_back(w);
      exp_q[b].push_back(w);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      for (int b = 0; b < 4; b++) begin
         if (acc[b] && (src_q[b].size() != 0)) void'(src_q[b].pop_front());
      end
      drive();
   endtask

   task automatic clear_logs();
      out_src.delete();
      out_last.delete();
      out_data.delete();
      exp_src.delete();
   endtask

   task automatic wait_deliv(input int n, input int budget);
      int c;
      c = 0;
      while ((out_src.size() < n) && (c < budget)) begin
         tick();
         c++;
      end
      if (out_src.size() < n) begin
         total++;
         bad++;
         $display("FAIL timeout: got %0d words expected %0d", out_src.size(), n);
      end
   endtask

   task automatic check_srcs(input string name);
      chk({name, "_count"}, WIDTH'(out_src.size()), WIDTH'(exp_src.size()));
      for (int i = 0; i < exp_src.size(); i++) begin
         if (i < out_src.size()) chk(name, WIDTH'(out_src[i]), WIDTH'(exp_src[i]));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      word_t w;
      word_t snap;
      int    c;
      rst           = 1'b1;
      bus.i_ordered = 1'b0;
      bus.i_ready   = 1'b1;
      drive();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_o_valid", WIDTH'(bus.o_valid), '0);
      chk("rst_o_data",  bus.o_data, '0);
      chk("rst_o_src",   WIDTH'(bus.o_src), '0);
      chk("rst_o_last",  WIDTH'(bus.o_last), '0);
      chk("rst_o_busy",  WIDTH'(bus.o_busy), '0);
      chk("rst_ready",   WIDTH'(rdy_vec()), '0);
      rst = 1'b0;

      // idle: nothing offered, nothing comes out
      repeat (10) tick();
      chk("idle_words", WIDTH'(out_src.size()), '0);

      // round-robin, all banks valid
      clear_logs();
      en = 4'b1111;
      for (int r = 0; r < 2; r++)
         for (int b = 0; b < 4; b++) push(b, WIDTH'(8'hA0 + b));
      drive();
      wait_deliv(8, 40);
      exp_src = '{0, 1, 2, 3, 0, 1, 2, 3};
      check_srcs("rr_all");
      if (out_data.size() > 1) begin
         chk("rr_data0", out_data[0], 256'hA0);
         chk("rr_data1", out_data[1], 256'hA1);
      end
      repeat (3) tick();

      // round-robin, banks 1 and 3 only
      clear_logs();
      en = 4'b1010;
      for (int r = 0; r < 2; r++) begin
         push(1, 256'hB1);
         push(3, 256'hB3);
      end
      drive();
      wait_deliv(4, 30);
      exp_src = '{1, 3, 1, 3};
      check_srcs("rr_13");
      repeat (3) tick();

      // ordered: bank 2 waits until bank 0 has gone
      clear_logs();
      bus.i_ordered = 1'b1;
      en = 4'b0100;
      push(2, 256'hC2);
      drive();
      repeat (3) tick();
      chk("ord_hold", WIDTH'(out_src.size()), '0);
      en = 4'b0101;
      push(0, 256'hC0);
      drive();
      repeat (2) tick();
      en = 4'b1111;
      push(1, 256'hC1);
      push(3, 256'hC3);
      drive();
      wait_deliv(4, 30);
      exp_src = '{0, 1, 2, 3};
      check_srcs("ord");
      for (int i = 0; i < 4; i++) begin
         if (i < out_last.size()) chk("ord_last", WIDTH'(out_last[i]), WIDTH'(exp_src[i] == 3));
      end
      repeat (3) tick();
      chk("ord_busy_idle", WIDTH'(bus.o_busy), '0);

      // backpressure with random words, per-bank in-order scoreboard
      clear_logs();
      bus.i_ordered = 1'b0;
      bus.i_ready   = 1'b0;
      en = 4'b1111;
      for (int b = 0; b < 4; b++) begin
         for (int n = 0; n < 100; n++) begin
            for (int j = 0; j < 8; j++) w[j*32 +: 32] = $urandom();
            push(b, w);
         end
      end
      drive();
      repeat (2) tick();
      snap = bus.o_data;
      for (int s = 0; s < 5; s++) begin
         tick();
         chk("stall_data", bus.o_data, snap);
         chk("stall_ready", WIDTH'(rdy_vec()), '0);
      end
      bus.i_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("refill_ready", WIDTH'(|rdy_vec()), WIDTH'(1'b1));
      c = 0;
      while ((out_src.size() < 400) && (c < 3000)) begin
         tick();
         bus.i_ready = ($urandom_range(0, 3) != 0);
         c++;
      end
      bus.i_ready = 1'b1;
      repeat (3) tick();
      chk("sb_total", WIDTH'(out_src.size()), WIDTH'(400));
      for (int b = 0; b < 4; b++) chk("sb_left", WIDTH'(exp_q[b].size()), '0);

      // leaving ordered mode mid-row restarts the next row at bank 0
      clear_logs();
      bus.i_ordered = 1'b1;
      en = 4'b0011;
      push(0, 256'hD0);
      push(1, 256'hD1);
      drive();
      wait_deliv(2, 20);
      bus.i_ordered = 1'b0;
      repeat (2) tick();
      chk("toggle_busy", WIDTH'(bus.o_busy), '0);
      clear_logs();
      bus.i_ordered = 1'b1;
      en = 4'b1111;
      for (int b = 0; b < 4; b++) push(b, WIDTH'(8'hE0 + b));
      drive();
      wait_deliv(4, 20);
      exp_src = '{0, 1, 2, 3};
      check_srcs("toggle_restart");
      repeat (3) tick();

      // asynchronous reset in the middle of a stream
      clear_logs();
      bus.i_ordered = 1'b0;
      en = 4'b1111;
      for (int b = 0; b < 4; b++)
         for (int n = 0; n < 3; n++) push(b, WIDTH'(8'hF0 + b));
      drive();
      repeat (2) tick();
      chk("pre_rst_valid", WIDTH'(bus.o_valid), WIDTH'(1'b1));
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", WIDTH'(bus.o_valid), '0);
      chk("async_rst_busy",  WIDTH'(bus.o_busy), '0);
      chk("async_rst_ready", WIDTH'(rdy_vec()), '0);
      repeat (2) @(posedge clk);
      #1;
      for (int b = 0; b < 4; b++) begin
         src_q[b].delete();
         exp_q[b].delete();
      end
      en = 4'b0000;
      drive();
      rst = 1'b0;
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/pim_bank_gather.md
Name: pim_bank_gather

Overview:
- Collects result words from the four PIM banks onto one registered output stream toward the bus-side read path.
- Performs the reverse of the write-side 1-to-4 bank steering.
- Each bank channel uses a valid/ready handshake. The block arbitrates round-robin, or in strict bank order when a full row is being reassembled.
- The output is a single register stage, so full throughput is one word per cycle.

Parameters:
WIDTH, 256, data width of each bank channel and of the output word

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst  input  1  asynchronous active-high reset
i_ordered  input  1  1 = strict order 0,1,2,3,0..; 0 = round-robin among valid banks
i_valid0..i_valid3  input  1 each  bank N offers a word
i_data0..i_data3  input  WIDTH each  bank N word
o_ready0..o_ready3  output  1 each  bank N word accepted this cycle (valid & ready)
o_valid  output  1  output register holds a word
o_data  output  WIDTH  output word
o_src  output  2  bank index the word came from
o_last  output  1  word is bank 3 of an ordered sequence (always 0 when i_ordered=0)
i_ready  input  1  downstream accepts the output word
o_busy  output  1  o_valid, or ordered sequence index != 0

Behaviour:
- Reset (async, immediate):
  - Outputs: o_valid=0, o_data=0, o_src=0, o_last=0, o_busy=0.
  - Internal: round-robin pointer=0 (bank 0 highest priority), ordered index=0.
  - o_ready0..3 are 0 while i_rst is high.
- load_ok = !o_valid | i_ready. The output register may be refilled in the same cycle it drains.
- Grant (combinational):
  - Ordered mode: grant = ordered index, if that bank's i_valid is high. Other banks are never granted, even if valid.
  - Round-robin mode: grant = first valid bank scanning pointer, pointer+1, ... mod 4.
  - No grant if no eligible bank is valid.
- o_readyN = load_ok & granted(N). At most one o_readyN is high per cycle. o_readyN depends on i_validN (permitted).
- On a transfer from bank g, at the clock edge:
  - o_data<=i_data_g, o_src<=g, o_valid<=1.
  - o_last<=(i_ordered & g==3).
  - Round-robin mode: pointer<=g+1 mod 4.
  - Ordered mode: ordered index<=g+1 mod 4, wrapping 3->0.
- If load_ok and no transfer: o_valid<=0. o_data, o_src and o_last hold their last values.
- If o_valid & !i_ready: the output is stalled. o_data, o_src and o_last are stable, and no o_readyN is asserted.
- Latency: one cycle from input transfer to o_valid.
- Throughput: back-to-back transfers sustain 1 word/cycle while i_ready=1.
- Bank sources must hold i_validN and i_dataN until o_readyN. The block never drops or duplicates a word.
- i_ordered=0 forces the ordered index to 0 on every cycle.
- Switching i_ordered from 0 to 1: the sequence starts at bank 0. Changing i_ordered while the ordered index != 0 is a usage error; the block's defined response is that the index resets to 0.
- Pointer and ordered index are independent. Ordered mode does not update the pointer.
- Reset asserted mid-sequence or mid-stall: the word in the output register is discarded and the ordered index returns to 0.

Test Plan:
- Reset, then all valids low, i_ready=1 → o_valid=0 and o_ready0..3=0 for 10 cycles. Assert i_rst mid-stream → o_valid falls asynchronously.
- Round-robin, all four banks valid continuously, i_ready=1 → o_src sequence 0,1,2,3,0,1 with o_valid=1 every cycle after the first. Check data = bank tag, e.g. 256'hA0..A3.
- Round-robin, banks 1 and 3 valid only → o_src alternates 1,3,1,3. Banks 0 and 2 get o_ready=0.
- Ordered mode, bank 2 valid first, then bank 0 two cycles later, then 1 and 3 → nothing is granted until bank 0. Output order is 0,1,2,3 and o_last=1 only on the src=3 word. o_busy is 0 after the final drain.
- Backpressure: i_ready=0 for 5 cycles with all banks valid → o_data stable and o_readyN all 0. On i_ready=1, output refills the same cycle with no lost word. Scoreboard 100 random words per bank shows in-order delivery per bank.
- Toggle i_ordered 1→0 after banks 0 and 1 → ordered index resets. Next ordered run starts again at bank 0.
